// File: rtl/lfsr_checker.sv
// Serial LFSR sequence checker: self-synchronises to a generator stream sharing the
// same tap vector, declares lock, then flags and counts every deviating bit.
module lfsr_checker #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned LOCK_COUNT  = 8,
  parameter int unsigned WINDOW      = 32,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reinit,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] taps,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             locked,
  output logic             bit_err,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] out_state
);

  localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WIN_W   = $clog2(WINDOW + 1);
  localparam int unsigned WERR_W  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   shadow, shadow_nxt;
  logic [FILL_W-1:0]  fill_cnt, fill_nxt;
  logic [MATCH_W-1:0] match_cnt, match_nxt;
  logic [WIN_W-1:0]   win_bits, win_bits_nxt;
  logic [WERR_W-1:0]  win_err, win_err_nxt;
  logic [CNT_W-1:0]   err_nxt;
  logic               locked_nxt;
  logic               bit_err_nxt;
  logic               pred;
  logic               mismatch;
  logic               counted;
  logic [WIDTH-1:0]   shift_rx;
  logic [WIDTH-1:0]   shift_pred;

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SEARCH;
      shadow    <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_bits  <= '0;
      win_err   <= '0;
      err_count <= '0;
      locked    <= 1'b0;
      bit_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      shadow    <= shadow_nxt;
      fill_cnt  <= fill_nxt;
      match_cnt <= match_nxt;
      win_bits  <= win_bits_nxt;
      win_err   <= win_err_nxt;
      err_count <= err_nxt;
      locked    <= locked_nxt;
      bit_err   <= bit_err_nxt;
    end
  end

  assign out_state = shadow;

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    shadow_nxt   = shadow;
    fill_nxt     = fill_cnt;
    match_nxt    = match_cnt;
    win_bits_nxt = win_bits;
    win_err_nxt  = win_err;
    bit_err_nxt  = 1'b0;
    counted      = 1'b0;
    pred         = ^(taps & shadow);
    mismatch     = in_bit ^ pred;
    shift_rx     = {shadow[WIDTH-2:0], in_bit};
    shift_pred   = {shadow[WIDTH-2:0], pred};

    if (reinit) begin
      state_nxt    = SEARCH;
      shadow_nxt   = '0;
      fill_nxt     = '0;
      match_nxt    = '0;
      win_bits_nxt = '0;
      win_err_nxt  = '0;
    end else if (in_valid) begin
      case (state)
        SEARCH: begin
          shadow_nxt = shift_rx;
          if (fill_cnt != FILL_W'(WIDTH)) begin
            fill_nxt = fill_cnt + FILL_W'(1);
          end
          // An all-zero register is a fixed point of the LFSR, never a lock candidate
          if ((fill_cnt >= FILL_W'(WIDTH - 1)) && (|shift_rx)) begin
            state_nxt = VERIFY;
            match_nxt = '0;
          end
        end
        VERIFY: begin
          shadow_nxt = shift_rx;
          if (~|shift_rx) begin
            state_nxt = SEARCH;
            fill_nxt  = '0;
          end else if (!mismatch) begin
            if (match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
              state_nxt    = LOCKED;
              match_nxt    = '0;
              win_bits_nxt = '0;
              win_err_nxt  = '0;
            end else begin
              match_nxt = match_cnt + MATCH_W'(1);
            end
          end else begin
            match_nxt = '0;
          end
        end
        LOCKED: begin
          bit_err_nxt = mismatch;
          counted     = mismatch;
          if (mismatch && (win_err == WERR_W'(LOSS_THRESH - 1))) begin
            // Lock lost: the register keeps its last predicted contents
            state_nxt    = SEARCH;
            fill_nxt     = '0;
            win_bits_nxt = '0;
            win_err_nxt  = '0;
          end else begin
            // Free-run on the prediction so a bad bit cannot poison later ones
            shadow_nxt = shift_pred;
            if (win_bits == WIN_W'(WINDOW - 1)) begin
              win_bits_nxt = '0;
              win_err_nxt  = '0;
            end else begin
              win_bits_nxt = win_bits + WIN_W'(1);
              win_err_nxt  = win_err + WERR_W'(mismatch);
            end
          end
        end
        default: begin
          state_nxt = SEARCH;
          fill_nxt  = '0;
        end
      endcase
    end

    err_nxt = err_count;
    if (clr_err) begin
      err_nxt = counted ? CNT_W'(1) : '0;
    end else if (counted && (err_count != '1)) begin
      err_nxt = err_count + CNT_W'(1);
    end

    locked_nxt = (state_nxt == LOCKED);
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a behavioural model of the checker.
module tb_lfsr_checker;

  localparam int unsigned WIDTH       = 5;
  localparam int unsigned LOCK_COUNT  = 8;
  localparam int unsigned WINDOW      = 32;
  localparam int unsigned LOSS_THRESH = 4;
  localparam int unsigned CNT_W       = 4;
  localparam int          CNT_MAX     = (1 << CNT_W) - 1;

  localparam int M_SEARCH = 0;
  localparam int M_VERIFY = 1;
  localparam int M_LOCKED = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             reinit;
  logic             clr_err;
  logic [WIDTH-1:0] taps;
  logic             in_valid;
  logic             in_bit;
  logic             locked;
  logic             bit_err;
  logic [CNT_W-1:0] err_count;
  logic [WIDTH-1:0] out_state;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  lfsr_checker #(
    .WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT), .WINDOW(WINDOW),
    .LOSS_THRESH(LOSS_THRESH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .reinit(reinit), .clr_err(clr_err), .taps(taps),
    .in_valid(in_valid), .in_bit(in_bit), .locked(locked), .bit_err(bit_err),
    .err_count(err_count), .out_state(out_state)
  );

  // Behavioural model: history of accepted bits, newest at index 0
  int m_mode, m_fill, m_match, m_wb, m_we, m_err;
  bit m_bit_err;
  bit hist[WIDTH];

  logic [WIDTH-1:0] gen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] hist_vec();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH; i++) v[i] = hist[i];
    return v;
  endfunction

  function automatic bit hist_zero();
    bit z;
    z = 1'b1;
    for (int i = 0; i < WIDTH; i++) if (hist[i]) z = 1'b0;
    return z;
  endfunction

  function automatic bit predict();
    bit p;
    p = 1'b0;
    for (int i = 0; i < WIDTH; i++) if (taps[i] && hist[i]) p = ~p;
    return p;
  endfunction

  task automatic push(input bit x);
    for (int i = WIDTH - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
  endtask

  task automatic m_reset();
    m_mode = M_SEARCH; m_fill = 0; m_match = 0; m_wb = 0; m_we = 0;
    m_err = 0; m_bit_err = 1'b0;
    for (int i = 0; i < WIDTH; i++) hist[i] = 1'b0;
  endtask

  task automatic m_step();
    bit p, counted;
    m_bit_err = 1'b0;
    counted   = 1'b0;
    if (reinit) begin
      for (int i = 0; i < WIDTH; i++) hist[i] = 1'b0;
      m_mode = M_SEARCH; m_fill = 0; m_match = 0; m_wb = 0; m_we = 0;
    end else if (in_valid) begin
      p = predict();
      if (m_mode == M_SEARCH) begin
        push(in_bit);
        if (m_fill < WIDTH) m_fill++;
        if (m_fill == WIDTH && !hist_zero()) begin m_mode = M_VERIFY; m_match = 0; end
      end else if (m_mode == M_VERIFY) begin
        push(in_bit);
        if (hist_zero()) begin
          m_mode = M_SEARCH; m_fill = 0;
        end else if (in_bit == p) begin
          m_match++;
          if (m_match == LOCK_COUNT) begin m_mode = M_LOCKED; m_wb = 0; m_we = 0; end
        end else begin
          m_match = 0;
        end
      end else begin
        if (in_bit != p) begin m_bit_err = 1'b1; counted = 1'b1; m_we++; end
        m_wb++;
        if (m_we >= LOSS_THRESH) begin
          m_mode = M_SEARCH; m_fill = 0;
        end else begin
          push(p);
          if (m_wb == WINDOW) begin m_wb = 0; m_we = 0; end
        end
      end
    end
    if (clr_err) m_err = counted ? 1 : 0;
    else if (counted && m_err < CNT_MAX) m_err++;
  endtask

  // Every cycle the model and the DUT must agree
  always @(negedge clk) begin
    if (cmp_en) begin
      check("locked", 32'(locked), 32'(m_mode == M_LOCKED));
      check("bit_err", 32'(bit_err), 32'(m_bit_err));
      check("err_count", 32'(err_count), 32'(m_err));
      check("out_state", 32'(out_state), 32'(hist_vec()));
    end
  end

  task automatic step(input logic v, input logic b, input logic ri, input logic ce);
    in_valid = v; in_bit = b; reinit = ri; clr_err = ce;
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic gen_bit(output logic b);
    b   = ^(taps & gen);
    gen = {gen[WIDTH-2:0], b};
  endtask

  task automatic gen_step(input logic flip, input logic ce);
    logic b;
    gen_bit(b);
    step(1'b1, b ^ flip, 1'b0, ce);
  endtask

  initial begin
    logic b;
    rst = 1'b1; reinit = 1'b0; clr_err = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    taps = 5'b10100;
    gen  = 5'b00001;
    m_reset();
    #1 rst = 1'b0;
    #1;
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_bit_err", 32'(bit_err), 32'd0);
    check("reset_err_count", 32'(err_count), 32'd0);
    check("reset_out_state", 32'(out_state), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;

    // Lock acquisition on a clean stream
    for (int k = 1; k <= 13; k++) begin
      gen_step(1'b0, 1'b0);
      check("lock_latency", 32'(locked), 32'(k == 13));
    end
    for (int k = 0; k < 62; k++) begin
      gen_step(1'b0, 1'b0);
      check("clean_no_err", 32'(bit_err), 32'd0);
    end
    check("clean_err_count", 32'(err_count), 32'd0);

    // Single error while locked
    gen_step(1'b1, 1'b0);
    check("single_err_pulse", 32'(bit_err), 32'd1);
    check("single_err_count", 32'(err_count), 32'd1);
    check("single_err_locked", 32'(locked), 32'd1);
    for (int k = 0; k < 33; k++) begin
      gen_step(1'b0, 1'b0);
      check("post_err_clean", 32'(bit_err), 32'd0);
    end
    check("post_err_locked", 32'(locked), 32'd1);

    // Four errors inside one window drop lock on the fourth
    for (int j = 0; j <= 10; j++) begin
      gen_step((j == 0) || (j == 3) || (j == 7) || (j == 10), 1'b0);
      check("loss_locked", 32'(locked), 32'(j < 10));
    end
    check("loss_err_count", 32'(err_count), 32'd5);
    for (int k = 1; k <= 13; k++) begin
      gen_step(1'b0, 1'b0);
      check("relock_latency", 32'(locked), 32'(k == 13));
    end

    // Degenerate zero stream never locks
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 100; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("zero_locked", 32'(locked), 32'd0);
      check("zero_state", 32'(out_state), 32'd0);
    end

    // Reinit while verifying discards the bit and restarts acquisition
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) gen_step(1'b0, 1'b0);
    check("verify_not_locked", 32'(locked), 32'd0);
    gen_bit(b);
    step(1'b1, b, 1'b1, 1'b0);
    check("reinit_state", 32'(out_state), 32'd0);
    for (int k = 1; k <= 13; k++) begin
      gen_step(1'b0, 1'b0);
      check("reinit_relock", 32'(locked), 32'(k == 13));
    end

    // Clear, clear-with-mismatch, then build err_count to 7 without losing lock
    gen_step(1'b0, 1'b1);
    check("clr_err", 32'(err_count), 32'd0);
    gen_step(1'b1, 1'b1);
    check("clr_with_err", 32'(err_count), 32'd1);
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < 10; k++) gen_step(1'b0, 1'b0);
      gen_step(1'b1, 1'b0);
    end
    check("err_count_7", 32'(err_count), 32'd7);
    check("locked_before_rst", 32'(locked), 32'd1);

    // Asynchronous reset between clock edges
    in_valid = 1'b0; reinit = 1'b0; clr_err = 1'b0;
    #2 rst = 1'b0;
    m_reset();
    #1;
    check("async_locked", 32'(locked), 32'd0);
    check("async_bit_err", 32'(bit_err), 32'd0);
    check("async_err_count", 32'(err_count), 32'd0);
    check("async_out_state", 32'(out_state), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Gapped valid: one valid bit every three cycles
    for (int k = 1; k <= 13; k++) begin
      gen_step(1'b0, 1'b0);
      check("gapped_lock", 32'(locked), 32'(k == 13));
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      check("gapped_hold", 32'(locked), 32'(k == 13));
    end

    // Randomized traffic: errors, gaps, clears, reinits, a tap switch
    for (int i = 0; i < 3000; i++) begin
      logic v, ri, ce, fl;
      if (i == 1500) taps = 5'b10010;
      ri = (i == 1500) || ($urandom_range(0, 199) == 0);
      ce = ($urandom_range(0, 99) < 3);
      v  = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 99) < 6);
      if (v) begin
        gen_bit(b);
        step(1'b1, b ^ fl, ri, ce);
      end else begin
        step(1'b0, 1'($urandom_range(0, 1)), ri, ce);
      end
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial sequence checker for the LFSR pattern generator. It receives the one-bit stream the generator emits on `out`, self-synchronises to it using the same tap vector, and declares lock. Once locked, it flags and counts every bit that deviates from the predicted sequence. It sits at the receive end of PRBS/BIST links and scrambler test paths, sharing the `taps` encoding with the generator.

## Interface
- `WIDTH`, 5, LFSR length in bits (≥3)
- `LOCK_COUNT`, 8, consecutive correct predictions required to declare lock (1..255)
- `WINDOW`, 32, bit window for loss-of-lock evaluation (2..65535)
- `LOSS_THRESH`, 4, errors within one window that drop lock (1..WINDOW)
- `CNT_W`, 16, width of the saturating error counter

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `reinit`  in  1  synchronous resynchronise request
- `clr_err`  in  1  synchronous clear of `err_count`
- `taps`  in  WIDTH  feedback mask; bit i set means `shadow[i]` feeds the XOR
- `in_valid`  in  1  `in_bit` is a new stream bit this cycle
- `in_bit`  in  1  received serial bit (generator `out`)
- `locked`  out  1  sequence lock indicator
- `bit_err`  out  1  one-cycle pulse on a mismatch while locked
- `err_count`  out  CNT_W  saturating count of mismatches while locked
- `out_state`  out  WIDTH  current shadow register; bit 0 is the newest bit

## Operation
- Shadow register S[WIDTH-1:0], with S[0] the newest bit. Predicted bit p = ^(taps & S). Every accepted bit shifts S <= {S[WIDTH-2:0], x}.
- The FSM has three states: SEARCH, VERIFY and LOCKED. It enters SEARCH on reset and on `reinit`.
- SEARCH:
  - x = `in_bit`; `fill_cnt` increments, saturating at WIDTH.
  - When `fill_cnt` reaches WIDTH and the shifted S is nonzero, go to VERIFY with `match_cnt`=0.
  - If the shifted S is all-zero, stay in SEARCH. This prevents lock on the degenerate zero stream.
- VERIFY:
  - x = `in_bit`.
  - If `in_bit`==p, `match_cnt` increments; on reaching LOCK_COUNT, go to LOCKED and clear the window counters.
  - If `in_bit`!=p, `match_cnt`=0 and the FSM stays in VERIFY.
  - If the shifted S becomes all-zero, go to SEARCH with `fill_cnt`=0.
  - `bit_err` is never asserted in SEARCH or VERIFY.
- LOCKED:
  - x = p, so the received bit never enters S and one error cannot corrupt later predictions.
  - On a mismatch, pulse `bit_err`, increment `err_count` (saturating at 2^CNT_W-1), and increment `win_err`.
  - `win_bits` counts accepted bits. When it reaches WINDOW, both `win_bits` and `win_err` restart from 0.
  - When `win_err` reaches LOSS_THRESH (counting the current bit), go to SEARCH with `fill_cnt`=0 and S unchanged. Deassert `locked` on the same edge.
- Cycles without `in_valid` change nothing except `reinit`/`clr_err` effects.
- Priority of simultaneous events:
  - `reinit` beats `in_valid`: the bit is discarded, S=0, the FSM goes to SEARCH, and all counters except `err_count` are cleared.
  - `clr_err` together with a counted mismatch leaves `err_count`=1.
  - `clr_err` together with a saturated counter leaves 0 (or 1 if a mismatch is also counted).
- A `taps` change takes effect in the next prediction. There is no protection, and `reinit` is the intended companion.

## Timing
- All outputs are registered. Reset values:
  - `locked`=0, `bit_err`=0, `err_count`=0, `out_state`=0.
  - FSM in SEARCH with all internal counters 0.
- `out_state` reflects the shift on the cycle after the accepting edge.
- Lock latency from reset or `reinit`, with a clean stream: WIDTH fill bits plus LOCK_COUNT verified bits. `locked` rises on the edge that accepts the last of these bits.
- `bit_err` is high for exactly one cycle, on the edge that accepts the erroneous bit. `err_count` updates on the same edge.
- An asynchronous `rst` assertion mid-operation clears all state immediately, independent of `clk`.
- There is no backpressure: every `in_valid` bit is consumed, and back-to-back valid cycles are fully supported.

## Test plan
- Lock acquisition: WIDTH=5, taps=5'b10100, generator seeded with 5'b00001 and advancing every cycle, `in_valid`=1 continuously.
  - `locked` rises on the 13th valid bit (5+8).
  - No `bit_err` for the next 62 bits (two periods of 31); `err_count`=0.
- Single error: invert one bit after lock. Expect exactly one `bit_err` pulse and `err_count`=1. `locked` stays 1, and the following bits produce no further errors.
- Loss of lock: invert 4 bits within 32 after lock. `locked` falls on the 4th error edge. Clean bits that follow relock after 13 more valid bits.
- Zero stream: `in_bit`=0 with `in_valid`=1 for 100 cycles. The FSM stays in SEARCH, `locked`=0 and `out_state`=0.
- `reinit` in VERIFY with `in_valid` high on that cycle: the bit is discarded, `out_state`=0 next cycle, and the full 13-bit lock sequence is required again.
- Async reset mid-LOCKED with `err_count`=7: all outputs go to 0 before the next `clk` edge. Gapped `in_valid` (1 valid in 3 cycles) still locks after 13 valid bits.
